bounce_ctrl: RTL and testbench

Motion and sound sequencer for the screen-saver logo. Once per video frame it decides whether the logo moves, advances the X/Y position, reflects the logo off the screen edges, and schedules the ping/pong/go sound codes and mute window. It also owns the user speed setting driven by the increase/decrease velocity buttons. It sits between the VGA timing generator, which supplies `frame_tick`, and the logo renderer and sound generator, which consume `x_logo`, `y_logo`, `code_sound` and `mute`.

---
 rtl/bounce_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_bounce_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bounce_ctrl.sv
// bounce_ctrl: per-frame motion and sound sequencer for the screen-saver logo.
//
// Once per frame_tick it paces logo steps from the user speed setting. It
// advances X/Y, reflects the logo off the screen edges and schedules the
// pong/ping/go sound codes and the mute window. After reset the logo is held
// still for START_FRAMES-1 ticks before motion is enabled.
//
// Ports:
//   clk        in  1   system clock
//   clr        in  1   synchronous active-high reset
//   frame_tick in  1   one-cycle pulse per video frame
//   inc_vel    in  1   increase speed (debounced level, rising edge counts)
//   dec_vel    in  1   decrease speed (debounced level, rising edge counts)
//   pause      in  1   freeze motion in RUN (only with BOUNCE_PAUSE_EN)
//   x_logo     out 10  logo left edge
//   y_logo     out 10  logo top edge
//   code_sound out 2   00 stop, 01 pong, 10 ping, 11 go
//   mute       out 1   silence request to the sound generator
//   speed      out 4   current speed setting (step period = 16 - speed frames)
//
// Build option: define BOUNCE_PAUSE_EN to add the pause input.
module bounce_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int WIDTH_LOGO   = 80,
  parameter int HEIGHT_LOGO  = 96,
  parameter int STEP_X       = 1,
  parameter int STEP_Y       = 2,
  parameter int SPEED_INIT   = 8,
  parameter int START_FRAMES = 60,
  parameter int SOUND_FRAMES = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       inc_vel,
  input  logic       dec_vel,
`ifdef BOUNCE_PAUSE_EN
  input  logic       pause,
`endif
  output logic [9:0] x_logo,
  output logic [9:0] y_logo,
  output logic [1:0] code_sound,
  output logic       mute,
  output logic [3:0] speed
);

  localparam int X_MAX = H_RES - WIDTH_LOGO;
  localparam int Y_MAX = V_RES - HEIGHT_LOGO;
  localparam logic [10:0] X_LIM  = 11'(X_MAX);
  localparam logic [10:0] Y_LIM  = 11'(Y_MAX);
  localparam logic [10:0] X_STEP = 11'(STEP_X);
  localparam logic [10:0] Y_STEP = 11'(STEP_Y);
  localparam logic [9:0]  X_HOME = 10'(X_MAX / 2);
  localparam logic [9:0]  Y_HOME = 10'(Y_MAX / 2);
  localparam logic [3:0]  SPEED_RST = 4'(SPEED_INIT);

  localparam int SC_W = (START_FRAMES > 2) ? $clog2(START_FRAMES) : 1;
  localparam logic [SC_W-1:0] START_LAST = SC_W'((START_FRAMES > 0) ? START_FRAMES - 1 : 0);
  localparam int ST_W = (SOUND_FRAMES > 1) ? $clog2(SOUND_FRAMES + 1) : 1;
  localparam logic [ST_W-1:0] SND_RELOAD = ST_W'(SOUND_FRAMES);

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_GO   = 2'b11;

  typedef enum logic {ST_START = 1'b0, ST_RUN = 1'b1} state_t;

  // Saturating +/-1; simultaneous up and down cancel.
  function automatic logic [3:0] sat_speed(input logic [3:0] s, input logic up, input logic dn);
    if (up && !dn && s != 4'd15) return s + 4'd1;
    if (dn && !up && s != 4'd0)  return s - 4'd1;
    return s;
  endfunction

  // One axis step in 11-bit arithmetic, clamped to [0, lim].
  // Returns {bounce, new_dir_positive, new_pos}.
  function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir_pos,
                                            input logic [10:0] step, input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] d;
    p = {1'b0, pos};
    s = p + step;
    d = p - step;
    if (dir_pos) begin
      if (s >= lim) return {1'b1, 1'b0, lim[9:0]};
      return {1'b0, 1'b1, s[9:0]};
    end
    if (p <= step) return {1'b1, 1'b1, 10'd0};
    return {1'b0, 1'b0, d[9:0]};
  endfunction

  state_t          state_q;
  state_t          state_n;
  logic            run_en;
  logic [SC_W-1:0] start_cnt_q;
  logic [SC_W-1:0] start_nxt;
  logic [3:0]      frame_cnt_q;
  logic            dir_x_q;
  logic            dir_y_q;
  logic [ST_W-1:0] snd_tmr_q;
  logic            inc_d_q;
  logic            dec_d_q;
  logic            freeze;
  logic [3:0]      step_thr;
  logic            step_due;
  logic [11:0]     x_res;
  logic [11:0]     y_res;
  logic            bx;
  logic            by;

`ifdef BOUNCE_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  assign start_nxt = start_cnt_q + SC_W'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_START;
    else     state_q <= state_n;
  end

  // FSM next state: START leaves on the tick that brings the count to START_LAST
  always_comb begin
    state_n = state_q;
    if (state_q == ST_START && frame_tick && start_nxt >= START_LAST) state_n = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    run_en = 1'b0;
    if (state_q == ST_RUN) run_en = 1'b1;
  end

  // Step pacing: period-1 = 15-speed; ">=" lets a speed increase step at once
  assign step_thr = 4'd15 - speed;
  assign step_due = frame_tick && run_en && !freeze && (frame_cnt_q >= step_thr);

  assign x_res = step_axis(x_logo, dir_x_q, X_STEP, X_LIM);
  assign y_res = step_axis(y_logo, dir_y_q, Y_STEP, Y_LIM);
  assign bx    = x_res[11];
  assign by    = y_res[11];

  // Registered outputs and state, updated on the edge that samples frame_tick
  always_ff @(posedge clk) begin
    if (clr) begin
      x_logo      <= X_HOME;
      y_logo      <= Y_HOME;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      speed       <= SPEED_RST;
      frame_cnt_q <= '0;
      code_sound  <= SND_GO;
      mute        <= 1'b0;
      snd_tmr_q   <= SND_RELOAD;
      start_cnt_q <= '0;
      inc_d_q     <= 1'b0;
      dec_d_q     <= 1'b0;
    end else begin
      inc_d_q <= inc_vel;
      dec_d_q <= dec_vel;
      speed   <= sat_speed(speed, inc_vel & ~inc_d_q, dec_vel & ~dec_d_q);

      if (state_q == ST_START && frame_tick) start_cnt_q <= start_nxt;

      if (frame_tick && run_en && !freeze) begin
        if (step_due) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_q + 4'd1;
      end

      if (step_due) begin
        x_logo  <= x_res[9:0];
        dir_x_q <= x_res[10];
        y_logo  <= y_res[9:0];
        dir_y_q <= y_res[10];
      end

      // A bounce pre-empts whatever sound is playing, including one expiring now
      if (step_due && (bx || by)) begin
        code_sound <= (bx && by) ? SND_GO : (bx ? SND_PONG : SND_PING);
        mute       <= 1'b0;
        snd_tmr_q  <= SND_RELOAD;
      end else if (frame_tick && snd_tmr_q != '0) begin
        snd_tmr_q <= snd_tmr_q - ST_W'(1);
        if (snd_tmr_q == ST_W'(1)) begin
          mute       <= 1'b1;
          code_sound <= SND_STOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_bounce_ctrl.sv
module tb_bounce_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, frame_tick, inc_vel, dec_vel;
  logic [9:0] x_logo, y_logo;
  logic [1:0] code_sound;
  logic       mute;
  logic [3:0] speed;

  logic       clr2, tick2, zero;
  logic [9:0] x2, y2;
  logic [1:0] code2;
  logic       mute2;
  logic [3:0] speed2;

  bounce_ctrl u_dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .inc_vel(inc_vel), .dec_vel(dec_vel),
    .x_logo(x_logo), .y_logo(y_logo), .code_sound(code_sound), .mute(mute), .speed(speed)
  );

  // Square playfield (max 80 on both axes, start 40/40, step 2) so X and Y hit the corner together
  bounce_ctrl #(
    .H_RES(100), .V_RES(100), .WIDTH_LOGO(20), .HEIGHT_LOGO(20),
    .STEP_X(2), .STEP_Y(2), .SPEED_INIT(15), .START_FRAMES(2), .SOUND_FRAMES(8)
  ) u_corner (
    .clk(clk), .clr(clr2), .frame_tick(tick2), .inc_vel(zero), .dec_vel(zero),
    .x_logo(x2), .y_logo(y2), .code_sound(code2), .mute(mute2), .speed(speed2)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] code;
    logic       mute;
    logic [3:0] spd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   checks = 0;
  int   failures = 0;
  int   since, snd;
  logic tick_d = 1'b0, tick2_d = 1'b0;

  always @(posedge clk) begin
    tick_d  <= frame_tick;
    tick2_d <= tick2;
  end

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_item(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                          input logic [1:0] c, input logic m, input logic [3:0] s);
    cmp({tag, ".x_logo"}, int'(x), int'(e.x));
    cmp({tag, ".y_logo"}, int'(y), int'(e.y));
    cmp({tag, ".code_sound"}, int'(c), int'(e.code));
    cmp({tag, ".mute"}, int'(m), int'(e.mute));
    cmp({tag, ".speed"}, int'(s), int'(e.spd));
  endtask

  // Monitors: outputs are presented one cycle after each sampled tick
  always @(negedge clk) begin
    if (tick_d) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL main_unexpected_output actual=output required=no_output at %0t", $time);
      end else begin
        e1 = q1.pop_front();
        cmp_item("main", e1, x_logo, y_logo, code_sound, mute, speed);
      end
    end
  end

  always @(negedge clk) begin
    if (tick2_d) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL corner_unexpected_output actual=output required=no_output at %0t", $time);
      end else begin
        e2 = q2.pop_front();
        cmp_item("corner", e2, x2, y2, code2, mute2, speed2);
      end
    end
  end

  function automatic exp_t mk(input int x, input int y, input int c, input int m, input int s);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.code = 2'(c); e.mute = 1'(m); e.spd = 4'(s);
    return e;
  endfunction

  // Triangle-wave position from the unfolded distance travelled
  function automatic int fold(input int u, input int mx);
    int m;
    m = u % (2 * mx);
    return (m <= mx) ? m : 2 * mx - m;
  endfunction

  function automatic bit hit(input int u, input int mx);
    return (u % mx) == 0;
  endfunction

  // Push the expected response for one tick, then issue the tick
  task automatic tick_exp(input bit sel, input int x, input int y, input int spd,
                          input bit bx, input bit by);
    exp_t e;
    if (bx || by) begin
      snd   = (bx && by) ? 3 : (bx ? 1 : 2);
      since = 0;
    end else begin
      since++;
    end
    e = mk(x, y, (since >= 8) ? 0 : snd, (since >= 8) ? 1 : 0, spd);
    if (sel) begin
      q2.push_back(e);
      tick2 = 1'b1; @(posedge clk); #1; tick2 = 1'b0;
    end else begin
      q1.push_back(e);
      frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic press(input logic i, input logic d);
    inc_vel = i; dec_vel = d;
    repeat (3) @(posedge clk);
    #1;
    inc_vel = 1'b0; dec_vel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic step1(input int n, input int spd);
    tick_exp(1'b0, fold(280 + n, 560), fold(192 + 2 * n, 384), spd,
             hit(280 + n, 560), hit(192 + 2 * n, 384));
  endtask

  initial begin
    clr = 1'b1; frame_tick = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
    clr2 = 1'b1; tick2 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;

    cmp("rst.x_logo", int'(x_logo), 280);
    cmp("rst.y_logo", int'(y_logo), 192);
    cmp("rst.code_sound", int'(code_sound), 3);
    cmp("rst.mute", int'(mute), 0);
    cmp("rst.speed", int'(speed), 8);

    // 59 START ticks, then 7 RUN ticks without a step; go expires after 8 ticks
    since = 0; snd = 3;
    for (int k = 1; k <= 66; k++) tick_exp(1'b0, 280, 192, 8, 1'b0, 1'b0);
    step1(1, 8);

    // 7 presses reach 15, the 8th saturates; then every tick steps
    repeat (8) press(1'b1, 1'b0);
    for (int n = 2; n <= 300; n++) step1(n, 15);

    // One decrement, then simultaneous edges cancel: speed 14, period 2
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    tick_exp(1'b0, 540, 24, 14, 1'b0, 1'b0);
    step1(301, 14);

    // Back to 8, then 16 decrements saturate at 0 (period 16)
    repeat (6) press(1'b0, 1'b1);
    tick_exp(1'b0, 539, 26, 8, 1'b0, 1'b0);
    repeat (16) press(1'b0, 1'b1);
    for (int k = 0; k < 14; k++) tick_exp(1'b0, 539, 26, 0, 1'b0, 1'b0);
    step1(302, 0);

    // Reset coincident with a tick: reset values next cycle, back in START
    q1.push_back(mk(280, 192, 3, 0, 8));
    clr = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; frame_tick = 1'b0;
    @(posedge clk); #1;
    since = 0; snd = 3;
    for (int k = 1; k <= 10; k++) tick_exp(1'b0, 280, 192, 8, 1'b0, 1'b0);

    // Corner instance: both axes reach 80 on step 20 -> go
    clr2 = 1'b0;
    cmp("corner_rst.x_logo", int'(x2), 40);
    cmp("corner_rst.y_logo", int'(y2), 40);
    since = 0; snd = 3;
    tick_exp(1'b1, 40, 40, 15, 1'b0, 1'b0);
    for (int n = 1; n <= 21; n++)
      tick_exp(1'b1, fold(40 + 2 * n, 80), fold(40 + 2 * n, 80), 15,
               hit(40 + 2 * n, 80), hit(40 + 2 * n, 80));

    repeat (3) @(posedge clk);
    #1;
    cmp("main_queue_drained", q1.size(), 0);
    cmp("corner_queue_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
